// File: rtl/fb_update_queue_pkg.sv
// Shared types and widths for the frame-buffer update queue.
package fb_update_queue_pkg;

   localparam int unsigned COLOR_W = 6;
   localparam int unsigned X_W     = 7;
   localparam int unsigned Y_W     = 8;
   localparam int unsigned LEVEL_W = 5;
   localparam int unsigned MEM_AW  = X_W + Y_W;

   typedef logic [COLOR_W-1:0] color_t;
   typedef logic [X_W-1:0]     x_t;
   typedef logic [Y_W-1:0]     y_t;
   typedef logic [MEM_AW-1:0]  mem_addr_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLR_WAIT = 2'd1,
      ST_CLEARING = 2'd2
   } fbq_state_e;

   typedef struct packed {
      y_t     y;
      x_t     x;
      color_t color;
   } px_upd_t;

   // Frame memory is addressed row-major: {row, col}.
   function automatic mem_addr_t mem_addr(input y_t y, input x_t x);
      return {y, x};
   endfunction

endpackage

// File: rtl/fb_update_queue_if.sv
// Producer and VGA-controller signals of the frame-buffer update queue.
interface fb_update_queue_if;
   import fb_update_queue_pkg::*;

   logic                 px_valid;
   x_t                   px_x;
   y_t                   px_y;
   color_t               px_color;
   logic                 px_ready;
   logic                 clr_req;
   color_t               clr_color;
   logic                 busy;
   logic [LEVEL_W-1:0]   level;
   x_t                   hor_addr;
   y_t                   ver_addr;
   logic                 read;
   logic                 write;
   color_t               data;

   modport slave (
      input  px_valid, px_x, px_y, px_color, clr_req, clr_color,
             hor_addr, ver_addr, read, write,
      output px_ready, busy, level, data
   );

   modport master (
      output px_valid, px_x, px_y, px_color, clr_req, clr_color,
             hor_addr, ver_addr, read, write,
      input  px_ready, busy, level, data
   );

endinterface

// File: rtl/fb_update_queue_px_fifo.sv
// Pending pixel-update FIFO; power-of-two depth, pointers wrap naturally.
module px_fifo
   import fb_update_queue_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  px_upd_t       din,
   input  logic          pop,
   output px_upd_t       dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   px_upd_t       store [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full  = (count_q == LW'(DEPTH));
   assign empty = (count_q == '0);
   assign level = count_q;
   assign dout  = store[rptr_q];

   always_comb begin
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) store[wptr_q] <= din;
   end

endmodule

// File: rtl/fb_update_queue.sv
// Queues pixel updates and applies them, or a full-frame clear, to the frame
// memory during the VGA controller's write slots.
module fb_update_queue
   import fb_update_queue_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLR_LAST_ROW = 150
) (
   input logic              clk,
   input logic              rst,
   fb_update_queue_if.slave bus
);

   localparam int unsigned FIFO_LW = $clog2(FIFO_DEPTH) + 1;

   fbq_state_e         state_q, state_d;
   color_t             clr_color_q, clr_color_d;
   logic               write_prev_q, write_prev_d;
   logic               ready_en_q, ready_en_d;
   logic               read_q, read_d;
   color_t             rd_word_q;
   mem_addr_t          rd_addr_d;

   logic               fifo_push;
   logic               fifo_pop;
   px_upd_t            fifo_din;
   px_upd_t            fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_LW-1:0] fifo_level;

   logic               mem_we;
   mem_addr_t          mem_waddr;
   color_t             mem_wdata;

   color_t             frame_mem [1 << MEM_AW];

   // Ready depends only on full, so a pop cannot free a slot in the same cycle.
   assign bus.px_ready = ready_en_q & ~fifo_full;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.level    = LEVEL_W'(fifo_level);
   assign bus.data     = read_q ? rd_word_q : '0;

   assign fifo_push = bus.px_valid & bus.px_ready;
   assign fifo_din  = '{y: bus.px_y, x: bus.px_x, color: bus.px_color};

   px_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_px_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d      = state_q;
      clr_color_d  = clr_color_q;
      write_prev_d = bus.write;
      ready_en_d   = 1'b1;
      read_d       = bus.read;
      rd_addr_d    = mem_addr(bus.ver_addr, bus.hor_addr);
      fifo_pop     = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = '0;
      mem_wdata    = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.write && !fifo_empty) begin
               fifo_pop  = 1'b1;
               mem_we    = 1'b1;
               mem_waddr = mem_addr(fifo_dout.y, fifo_dout.x);
               mem_wdata = fifo_dout.color;
            end
            if (bus.clr_req) begin
               state_d     = ST_CLR_WAIT;
               clr_color_d = bus.clr_color;
            end
         end
         ST_CLR_WAIT: begin
            // The frame-start slot itself is the first fill write.
            if (bus.write && (bus.ver_addr == '0)) begin
               state_d   = ST_CLEARING;
               mem_we    = 1'b1;
               mem_waddr = mem_addr(bus.ver_addr, bus.hor_addr);
               mem_wdata = clr_color_q;
            end
         end
         ST_CLEARING: begin
            if (bus.write) begin
               mem_we    = 1'b1;
               mem_waddr = mem_addr(bus.ver_addr, bus.hor_addr);
               mem_wdata = clr_color_q;
            end
            if (write_prev_q && !bus.write && (bus.ver_addr == Y_W'(CLR_LAST_ROW))) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         clr_color_q  <= '0;
         write_prev_q <= 1'b0;
         ready_en_q   <= 1'b0;
         read_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_color_q  <= clr_color_d;
         write_prev_q <= write_prev_d;
         ready_en_q   <= ready_en_d;
         read_q       <= read_d;
      end
   end

   // Frame memory and its read register are intentionally never reset.
   always_ff @(posedge clk) begin
      if (mem_we) frame_mem[mem_waddr] <= mem_wdata;
      rd_word_q <= frame_mem[rd_addr_d];
   end

endmodule

// File: tb/tb_fb_update_queue.sv
// Directed bench for fb_update_queue with a read-data scoreboard.
module tb_fb_update_queue;
   import fb_update_queue_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_dly = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [5:0]  exp_q [$];
   logic [5:0]  ref_mem [int];

   fb_update_queue_if bus ();

   fb_update_queue #(
      .FIFO_DEPTH   (16),
      .CLR_LAST_ROW (150)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   always #10 clk = ~clk;

   function automatic int key(input int y, input int x);
      return y * 128 + x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_px(input int x, input int y, input logic [5:0] c);
      bus.px_valid = 1'b1;
      bus.px_x     = 7'(x);
      bus.px_y     = 8'(y);
      bus.px_color = c;
      tick();
      bus.px_valid = 1'b0;
   endtask

   task automatic do_read(input int y, input int x);
      bus.read     = 1'b1;
      bus.ver_addr = 8'(y);
      bus.hor_addr = 7'(x);
      exp_q.push_back(ref_mem[key(y, x)]);
      tick();
      bus.read = 1'b0;
   endtask

   // Drive an abbreviated scan: 8 write slots per row, then one idle slot.
   task automatic scan_rows(input int first, input int last, input logic [5:0] fill);
      for (int y = first; y <= last; y++) begin
         for (int x = 0; x < 8; x++) begin
            bus.write    = 1'b1;
            bus.ver_addr = 8'(y);
            bus.hor_addr = 7'(x);
            tick();
            ref_mem[key(y, x)] = fill;
         end
         bus.write = 1'b0;
         tick();
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_dly <= 1'b0;
      else        rd_dly <= bus.read;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_dly) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL rd_unexpected: observed %0h expected none", bus.data);
            end else begin
               logic [5:0] e;
               e = exp_q.pop_front();
               checks++;
               assert (bus.data === e) else begin
                  errors++;
                  $error("FAIL rd_data: observed %0h expected %0h", bus.data, e);
               end
            end
         end else begin
            checks++;
            assert (bus.data === 6'h00) else begin
               errors++;
               $error("FAIL rd_idle_zero: observed %0h expected 0", bus.data);
            end
         end
      end
   end

   initial begin
      bus.px_valid  = 1'b0;
      bus.px_x      = '0;
      bus.px_y      = '0;
      bus.px_color  = '0;
      bus.clr_req   = 1'b0;
      bus.clr_color = '0;
      bus.hor_addr  = '0;
      bus.ver_addr  = '0;
      bus.read      = 1'b0;
      bus.write     = 1'b0;

      // Reset state
      #1;
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.px_ready), 0);
      chk("rst_data", 32'(bus.data), 0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("ready_before_edge", 32'(bus.px_ready), 0);
      tick();
      chk("ready_after_edge", 32'(bus.px_ready), 1);

      // Single update, then one drain slot
      push_px(5, 3, 6'h2A);
      chk("single_level", 32'(bus.level), 1);
      tick();
      chk("no_pop_write0", 32'(bus.level), 1);
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
      ref_mem[key(3, 5)] = 6'h2A;
      chk("single_drained", 32'(bus.level), 0);
      do_read(3, 5);

      // Fill the FIFO and try one more
      for (int i = 0; i < 16; i++) begin
         push_px(10 + i, 20, 6'(i + 32));
      end
      chk("full_level", 32'(bus.level), 16);
      chk("full_ready", 32'(bus.px_ready), 0);
      push_px(99, 99, 6'h11);
      chk("overflow_level", 32'(bus.level), 16);
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
      chk("after_pop_level", 32'(bus.level), 15);
      chk("after_pop_ready", 32'(bus.px_ready), 1);
      bus.write = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      bus.write = 1'b0;
      chk("full_drained", 32'(bus.level), 0);
      for (int i = 0; i < 16; i++) ref_mem[key(20, 10 + i)] = 6'(i + 32);
      for (int i = 0; i < 16; i++) do_read(20, 10 + i);

      // Sentinel outside the cleared rows
      push_px(0, 200, 6'h15);
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
      ref_mem[key(200, 0)] = 6'h15;

      // Clear requested mid-frame
      bus.ver_addr  = 8'd100;
      bus.hor_addr  = 7'd3;
      bus.clr_req   = 1'b1;
      bus.clr_color = 6'h3F;
      tick();
      bus.clr_req   = 1'b0;
      bus.clr_color = 6'h00;
      chk("clr_busy", 32'(bus.busy), 1);
      push_px(2, 2, 6'h07);
      bus.write    = 1'b1;
      bus.ver_addr = 8'd200;
      bus.hor_addr = 7'd0;
      tick();
      bus.ver_addr = 8'd101;
      tick();
      bus.write = 1'b0;
      chk("wait_no_pop", 32'(bus.level), 1);
      chk("wait_busy", 32'(bus.busy), 1);

      scan_rows(0, 0, 6'h3F);
      push_px(1, 1, 6'h01);
      chk("clearing_held", 32'(bus.level), 2);
      scan_rows(1, 149, 6'h3F);
      chk("busy_after_149", 32'(bus.busy), 1);
      chk("clearing_no_pop", 32'(bus.level), 2);
      for (int x = 0; x < 8; x++) begin
         bus.write    = 1'b1;
         bus.ver_addr = 8'd150;
         bus.hor_addr = 7'(x);
         tick();
         ref_mem[key(150, x)] = 6'h3F;
      end
      chk("busy_last_row", 32'(bus.busy), 1);
      bus.write = 1'b0;
      tick();
      chk("clr_done_busy", 32'(bus.busy), 0);
      bus.write = 1'b1;
      tick();
      chk("post_clr_drain1", 32'(bus.level), 1);
      tick();
      bus.write = 1'b0;
      chk("post_clr_drain2", 32'(bus.level), 0);
      ref_mem[key(2, 2)] = 6'h07;
      ref_mem[key(1, 1)] = 6'h01;
      foreach (ref_mem[k]) begin
         if ((k / 128) <= 150 || k == key(200, 0)) begin
            if ((k / 128) inside {0, 1, 2, 3, 75, 149, 150, 200}) do_read(k / 128, k % 128);
         end
      end

      // Reset in the middle of a second clear
      bus.clr_req   = 1'b1;
      bus.clr_color = 6'h0C;
      tick();
      bus.clr_req = 1'b0;
      scan_rows(0, 9, 6'h0C);
      for (int x = 0; x < 4; x++) begin
         bus.write    = 1'b1;
         bus.ver_addr = 8'd10;
         bus.hor_addr = 7'(x);
         tick();
         ref_mem[key(10, x)] = 6'h0C;
      end
      bus.write = 1'b0;
      push_px(5, 5, 6'h09);
      chk("rst2_pre_level", 32'(bus.level), 1);
      chk("rst2_pre_busy", 32'(bus.busy), 1);
      do_read(0, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_level", 32'(bus.level), 0);
      chk("abort_data", 32'(bus.data), 0);
      chk("abort_ready", 32'(bus.px_ready), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst2_ready", 32'(bus.px_ready), 1);
      chk("rst2_busy", 32'(bus.busy), 0);
      for (int x = 0; x < 8; x++) begin
         do_read(0, x);
         do_read(5, x);
         do_read(9, x);
         do_read(10, x);
         do_read(11, x);
      end
      do_read(75, 0);
      do_read(200, 0);

      tick();
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
